ysyx_25060170_wbu: RTL and testbench

- Write-back unit: the producer side of the GPR write port (`GPR_we` / `GPR_writer` / `GPR_wd`).
- Collects results from two sources, EXU (ALU/CSR results) and LSU (load data), over valid/ready handshakes.
- Buffers them in a small in-order FIFO and issues at most one registered GPR write per cycle.
- Exports a pending-destination bitmap that decode uses for RAW hazard detection.

---
 rtl/ysyx_25060170_wbu.sv | 155 +++++++++++++++
 tb/tb_ysyx_25060170_wbu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: arbitrates EXU/LSU results into a small in-order FIFO and
// drives one registered GPR write per cycle. Optional counters: WBU_PERF_CNT_EN.
module ysyx_25060170_wbu #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              wb_stall,
  output logic              GPR_we,
  output logic [ADDR_W-1:0] GPR_writer,
  output logic [DATA_W-1:0] GPR_wd,
  output logic [31:0]       rd_busy
`ifdef WBU_PERF_CNT_EN
  ,
  output logic [31:0]       wb_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] writer_q, writer_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              not_full, fifo_empty;
  logic              acc_lsu, acc_exu, accept;
  logic              pop, bypass, push;
  logic [ADDR_W-1:0] acc_rd;
  logic [DATA_W-1:0] acc_data;
  logic [FIFO_DEPTH-1:0] slot_vld;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the registered count so no path exists from wb_stall.
  assign not_full   = (count_q != DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign lsu_ready  = not_full;
  assign exu_ready  = not_full && !lsu_valid;

  assign acc_lsu  = lsu_valid && lsu_ready;
  assign acc_exu  = exu_valid && exu_ready;
  assign accept   = acc_lsu || acc_exu;
  assign acc_rd   = acc_lsu ? lsu_rd   : exu_rd;
  assign acc_data = acc_lsu ? lsu_data : exu_data;

  assign pop    = !wb_stall && !fifo_empty;
  assign bypass = !wb_stall && fifo_empty && accept;
  assign push   = accept && !bypass;

  always_comb begin
    we_d     = 1'b0;
    writer_d = writer_q;
    wd_d     = wd_q;
    if (!wb_stall) begin
      if (!fifo_empty) begin
        writer_d = fifo_rd_q[head_q];
        wd_d     = fifo_data_q[head_q];
        we_d     = |fifo_rd_q[head_q];
      end else if (accept) begin
        writer_d = acc_rd;
        wd_d     = acc_data;
        we_d     = |acc_rd;
      end
    end
    head_d  = pop  ? ptr_inc(head_q) : head_q;
    tail_d  = push ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      writer_q <= '0;
      wd_q     <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      we_q     <= we_d;
      writer_q <= writer_d;
      wd_q     <= wd_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count/head only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[tail_q]   <= acc_rd;
      fifo_data_q[tail_q] <= acc_data;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    localparam logic [CNT_W-1:0] IDX_C = CNT_W'(gi);
    logic [CNT_W-1:0] head_c;
    logic [CNT_W-1:0] off;
    assign head_c       = CNT_W'(head_q);
    assign off          = (IDX_C >= head_c) ? (IDX_C - head_c) : (IDX_C + DEPTH_C - head_c);
    assign slot_vld[gi] = (off < count_q);
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld[i]) rd_busy[fifo_rd_q[i]] = 1'b1;
    end
    if (we_q) rd_busy[writer_q] = 1'b1;
    rd_busy[0] = 1'b0;
  end

  assign GPR_we     = we_q;
  assign GPR_writer = writer_q;
  assign GPR_wd     = wd_q;

`ifdef WBU_PERF_CNT_EN
  logic [31:0] wb_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (we_d) wb_cnt_q <= wb_cnt_q + 32'd1;
      if (wb_stall && !fifo_empty) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign wb_cnt    = wb_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Scoreboard bench for ysyx_25060170_wbu: directed transactions push expected
// GPR writes; a negedge monitor pops and compares each GPR_we pulse.
module tb_ysyx_25060170_wbu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exu_valid, lsu_valid, wb_stall;
  logic        exu_ready, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_data, lsu_data;
  logic        GPR_we;
  logic [4:0]  GPR_writer;
  logic [31:0] GPR_wd;
  logic [31:0] rd_busy;
`ifdef WBU_PERF_CNT_EN
  logic [31:0] wb_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  ysyx_25060170_wbu dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_stall(wb_stall),
    .GPR_we(GPR_we), .GPR_writer(GPR_writer), .GPR_wd(GPR_wd),
    .rd_busy(rd_busy)
`ifdef WBU_PERF_CNT_EN
    , .wb_cnt(wb_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (GPR_we) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got x%0d=%h, expected no write", GPR_writer, GPR_wd);
      end else begin
        logic [36:0] exp;
        exp = sb_q.pop_front();
        check("gpr_write", {27'b0, GPR_writer, GPR_wd}, {27'b0, exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  // Holds the raised valids until each one handshakes; LSU priority is checked on the way.
  task automatic run_handshakes(input int max_cyc);
    int  n;
    bit  la, ea;
    n = 0;
    while ((lsu_valid || exu_valid) && n < max_cyc) begin
      @(negedge clk);
      if (lsu_valid) check("exu_ready_blocked_by_lsu", {63'b0, exu_ready}, 64'd0);
      la = lsu_valid && lsu_ready;
      ea = exu_valid && exu_ready;
      @(posedge clk);
      #1;
      if (la) lsu_valid = 1'b0;
      if (ea) exu_valid = 1'b0;
      n++;
    end
    check("handshake_done", {63'b0, (lsu_valid || exu_valid)}, 64'd0);
    lsu_valid = 1'b0;
    exu_valid = 1'b0;
  endtask

  task automatic exu_send(input logic [4:0] rd, input logic [31:0] data, input bit expect_write);
    if (expect_write) sb_q.push_back({rd, data});
    exu_rd    = rd;
    exu_data  = data;
    exu_valid = 1'b1;
    run_handshakes(8);
  endtask

  initial begin
    exu_valid = 1'b0; lsu_valid = 1'b0; wb_stall = 1'b0;
    exu_rd = '0; lsu_rd = '0; exu_data = '0; lsu_data = '0;

    // Power-on reset state
    #8;
    check("rst_we",     {63'b0, GPR_we},     64'd0);
    check("rst_writer", {59'b0, GPR_writer}, 64'd0);
    check("rst_wd",     {32'b0, GPR_wd},     64'd0);
    check("rst_ready",  {62'b0, lsu_ready, exu_ready}, 64'd3);
    check("rst_busy",   {32'b0, rd_busy},    64'd0);
    #4 rst = 1'b1;
    @(posedge clk); #1;

    // Single EXU write with bypass
    exu_send(5'd5, 32'h1234_5678, 1'b1);
    @(negedge clk);
    check("bypass_we",   {63'b0, GPR_we},  64'd1);
    check("busy_x5_on",  {32'b0, rd_busy}, 64'h20);
    @(negedge clk);
    check("busy_x5_off", {32'b0, rd_busy}, 64'd0);
    @(posedge clk); #1;

    // LSU and EXU together: LSU first, then EXU on the next cycle
    sb_q.push_back({5'd3, 32'h0000_000A});
    sb_q.push_back({5'd4, 32'h0000_000B});
    lsu_rd = 5'd3; lsu_data = 32'hA; lsu_valid = 1'b1;
    exu_rd = 5'd4; exu_data = 32'hB; exu_valid = 1'b1;
    run_handshakes(8);
    @(negedge clk);
    check("x4_back_to_back", {59'b0, GPR_writer}, 64'd4);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Write to x0 is consumed silently, x7 follows immediately
    exu_send(5'd0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    check("x0_no_we",   {63'b0, GPR_we},  64'd0);
    check("x0_no_busy", {32'b0, rd_busy}, 64'd0);
    @(posedge clk); #1;
    exu_send(5'd7, 32'h7777_7777, 1'b1);
    @(negedge clk);
    check("x7_we",   {63'b0, GPR_we},  64'd1);
    check("x7_busy", {32'b0, rd_busy}, 64'h80);
    @(posedge clk); #1;

    // Stall while filling: two accepted, third waits for the release
    wb_stall = 1'b1;
    exu_send(5'd1, 32'h1111_0001, 1'b1);
    exu_send(5'd2, 32'h2222_0002, 1'b1);
    sb_q.push_back({5'd3, 32'h3333_0003});
    exu_rd = 5'd3; exu_data = 32'h3333_0003; exu_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_ready",  {62'b0, lsu_ready, exu_ready}, 64'd0);
      check("stall_no_we", {63'b0, GPR_we}, 64'd0);
      check("stall_busy",  {32'b0, rd_busy}, 64'h6);
      check("stall_hold",  {27'b0, GPR_writer, GPR_wd}, {27'b0, 5'd7, 32'h7777_7777});
      @(posedge clk); #1;
    end
    wb_stall = 1'b0;
    run_handshakes(8);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;

    // Reset with two buffered entries: both are discarded
    wb_stall = 1'b1;
    exu_send(5'd12, 32'hDEAD_000C, 1'b0);
    exu_send(5'd13, 32'hDEAD_000D, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_we",    {63'b0, GPR_we},  64'd0);
    check("mid_rst_ready", {62'b0, lsu_ready, exu_ready}, 64'd3);
    check("mid_rst_busy",  {32'b0, rd_busy}, 64'd0);
    wb_stall = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_we",   {63'b0, GPR_we},  64'd0);
      check("post_rst_busy", {32'b0, rd_busy}, 64'd0);
    end
    @(posedge clk); #1;

`ifdef WBU_PERF_CNT_EN
    // 10 writes (two to x0) and 3 stalled edges with a non-empty FIFO
    wb_stall = 1'b1;
    exu_send(5'd9, 32'h0000_0900, 1'b1);
    repeat (3) @(posedge clk);
    #1 wb_stall = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [4:0] rd;
      rd = (i == 2 || i == 6) ? 5'd0 : 5'(10 + i);
      exu_send(rd, 32'hC000_0000 + 32'(i), rd != 5'd0);
    end
    repeat (4) @(negedge clk);
    check("wb_cnt",    {32'b0, wb_cnt},    64'd8);
    check("stall_cnt", {32'b0, stall_cnt}, 64'd3);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
